// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared pipeline types and constants for the hazard scoreboard
//
// Purpose: stage-record types, register-number width, PC register number and
// the source-match helper shared by the scoreboard top and its stage registers.
// Ports: none (package).
package hazard_scoreboard_pkg;

  localparam int REG_W = 4;
  localparam logic [REG_W-1:0] PC_REG = 4'd15;

  typedef logic [REG_W-1:0] reg_num_t;

  // Control and register fields tracked for every in-flight instruction.
  typedef struct packed {
    reg_num_t dest;
    reg_num_t rn;
    logic     reg_write;
    logic     write_back;
    logic     mem_to_reg;
    logic     pc_src;
  } stage_rec_t;

  // The E stage also remembers its source registers for forwarding compares.
  typedef struct packed {
    stage_rec_t ctl;
    reg_num_t   ra1;
    reg_num_t   ra2;
    reg_num_t   ra3;
  } e_rec_t;

  // The PC is never forwarded through the register file path, so a source of
  // R15 never produces a hazard regardless of what the older stage writes.
  function automatic logic src_match(input reg_num_t src, input reg_num_t tgt,
                                     input logic en);
    return en && (src == tgt) && (src != PC_REG);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_stage_reg.sv
// rtl/hazard_scoreboard_stage_reg.sv - parameterised pipeline record register with clear and bubble insert
//
// Purpose: holds one pipeline stage record; clears on reset, loads an all-zero
// bubble when asked, otherwise loads the upstream record every cycle.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-low clear
//   bubble - load an all-zero record instead of d
//   d      - upstream record
//   q      - registered record
module stage_reg #(
  parameter type rec_t = logic
) (
  input  logic clk,
  input  logic reset,
  input  logic bubble,
  input  rec_t d,
  output rec_t q
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (bubble) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - E/M/W register-hazard scoreboard with forwarding matches
//
// Purpose: tracks the destination, base register and control bits of the
// instructions in E, M and W, and reports source/destination matches used by
// the forwarding and stall logic, pending PC writes and pending register writes.
// Ports:
//   clk, reset                      - clock, synchronous active-low reset
//   RA1D/RA2D/RA3D/WA3D/RnD         - decode-stage register numbers
//   RegWriteD/WriteBackD/MemtoRegD/PCSrcD - decode-stage control bits
//   StallD, FlushE                  - hazard-unit controls
//   Match_kE_{M,W}                  - E source k equals M/W destination
//   Match_kE_{M,W}_Index            - E source k equals M/W write-back base
//   Match_12D_E                     - D source hits a load in E
//   PCWrPendingF                    - PC write in flight in D, E or M
//   PendingWrites                   - register writes in flight in E, M, W
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] RA1D,
  input  logic [REG_W-1:0] RA2D,
  input  logic [REG_W-1:0] RA3D,
  input  logic [REG_W-1:0] WA3D,
  input  logic [REG_W-1:0] RnD,
  input  logic             RegWriteD,
  input  logic             WriteBackD,
  input  logic             MemtoRegD,
  input  logic             PCSrcD,
  input  logic             StallD,
  input  logic             FlushE,
  output logic             Match_1E_M,
  output logic             Match_1E_W,
  output logic             Match_2E_M,
  output logic             Match_2E_W,
  output logic             Match_3E_M,
  output logic             Match_3E_W,
  output logic             Match_1E_M_Index,
  output logic             Match_1E_W_Index,
  output logic             Match_2E_M_Index,
  output logic             Match_2E_W_Index,
  output logic             Match_3E_M_Index,
  output logic             Match_3E_W_Index,
  output logic             Match_12D_E,
  output logic             PCWrPendingF,
  output logic [1:0]       PendingWrites
);

  e_rec_t     d_rec;
  e_rec_t     e_rec;
  stage_rec_t m_rec;
  stage_rec_t w_rec;

  always_comb begin
    d_rec = '0;
    d_rec.ctl.dest       = WA3D;
    d_rec.ctl.rn         = RnD;
    d_rec.ctl.reg_write  = RegWriteD;
    d_rec.ctl.write_back = WriteBackD;
    d_rec.ctl.mem_to_reg = MemtoRegD;
    d_rec.ctl.pc_src     = PCSrcD;
    d_rec.ra1            = RA1D;
    d_rec.ra2            = RA2D;
    d_rec.ra3            = RA3D;
  end

  // A stall of D is always accompanied by a flush of E, so the flush alone
  // decides what enters E; M and W advance every cycle.
  stage_reg #(.rec_t(e_rec_t)) u_stage_e (
    .clk    (clk),
    .reset  (reset),
    .bubble (FlushE),
    .d      (d_rec),
    .q      (e_rec)
  );

  stage_reg #(.rec_t(stage_rec_t)) u_stage_m (
    .clk    (clk),
    .reset  (reset),
    .bubble (1'b0),
    .d      (e_rec.ctl),
    .q      (m_rec)
  );

  stage_reg #(.rec_t(stage_rec_t)) u_stage_w (
    .clk    (clk),
    .reset  (reset),
    .bubble (1'b0),
    .d      (m_rec),
    .q      (w_rec)
  );

  // Destination matches; an instruction sitting in both M and W views is
  // reported at both, and the consumer picks the younger one.
  assign Match_1E_M = src_match(e_rec.ra1, m_rec.dest, m_rec.reg_write);
  assign Match_1E_W = src_match(e_rec.ra1, w_rec.dest, w_rec.reg_write);
  assign Match_2E_M = src_match(e_rec.ra2, m_rec.dest, m_rec.reg_write);
  assign Match_2E_W = src_match(e_rec.ra2, w_rec.dest, w_rec.reg_write);
  assign Match_3E_M = src_match(e_rec.ra3, m_rec.dest, m_rec.reg_write);
  assign Match_3E_W = src_match(e_rec.ra3, w_rec.dest, w_rec.reg_write);

  // Base-register write-back matches for indexed addressing.
  assign Match_1E_M_Index = src_match(e_rec.ra1, m_rec.rn, m_rec.write_back);
  assign Match_1E_W_Index = src_match(e_rec.ra1, w_rec.rn, w_rec.write_back);
  assign Match_2E_M_Index = src_match(e_rec.ra2, m_rec.rn, m_rec.write_back);
  assign Match_2E_W_Index = src_match(e_rec.ra2, w_rec.rn, w_rec.write_back);
  assign Match_3E_M_Index = src_match(e_rec.ra3, m_rec.rn, m_rec.write_back);
  assign Match_3E_W_Index = src_match(e_rec.ra3, w_rec.rn, w_rec.write_back);

  // Load-use: a load in E cannot forward to the instruction now in D.
  logic load_in_e;
  assign load_in_e   = e_rec.ctl.mem_to_reg & e_rec.ctl.reg_write;
  assign Match_12D_E = src_match(RA1D, e_rec.ctl.dest, load_in_e) |
                       src_match(RA2D, e_rec.ctl.dest, load_in_e);

  assign PCWrPendingF = PCSrcD | e_rec.ctl.pc_src | m_rec.pc_src;

  // At most three writers are in flight, so two bits never wrap.
  assign PendingWrites = {1'b0, e_rec.ctl.reg_write} +
                         {1'b0, m_rec.reg_write} +
                         {1'b0, w_rec.reg_write};

  // Fields carried through the pipeline but not consumed at these stages.
  logic [3:0] unused_bits;
  assign unused_bits = {StallD, m_rec.mem_to_reg, w_rec.mem_to_reg, w_rec.pc_src};

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-low reset; sampled only on a rising clk edge.
REQ-004 RA1D, RA2D, RA3D  input  4 each  decode-stage source register numbers.
REQ-005 WA3D  input  4  decode-stage destination register number.
REQ-006 RnD  input  4  decode-stage base register, written back by indexed addressing.
REQ-007 RegWriteD, WriteBackD, MemtoRegD, PCSrcD  input  1 each  decode-stage control bits.
REQ-008 StallD, FlushE  input  1 each  stall and flush controls from the hazard unit.
REQ-009 Match_{1,2,3}E_{M,W}  output  1 each  E-stage source equals the M/W destination.
REQ-010 Match_{1,2,3}E_{M,W}_Index  output  1 each  E-stage source equals the M/W base register.
REQ-011 Match_12D_E  output  1  RA1D or RA2D equals the E-stage destination of a load.
REQ-012 PCWrPendingF  output  1  a PC write is in flight in D, E or M.
REQ-013 PendingWrites  output  2  count of in-flight register writes in E, M and W (0..3).

Function
REQ-014 State SHALL be three stage records (E, M, W), each holding dest, Rn, RegWrite, WriteBack, MemtoReg and PCSrc; E additionally holds RA1E, RA2E and RA3E.
REQ-015 On each rising edge with reset high, W SHALL load M and M SHALL load E, unconditionally.
REQ-016 E load: if FlushE=1, E SHALL load a bubble (all control bits 0, all register fields 0); otherwise E SHALL load the D inputs.
REQ-017 StallD SHALL NOT block the E/M/W advance; a stall is always paired with FlushE, and FlushE takes priority.
REQ-018 Match_kE_X SHALL be (RAkE == destX) AND RegWriteX AND (RAkE != 15), for k in 1..3 and X in {M, W}.
REQ-019 Match_kE_X_Index SHALL be (RAkE == RnX) AND WriteBackX AND (RAkE != 15).
REQ-020 Match_12D_E SHALL be MemtoRegE AND RegWriteE AND ((RA1D == destE) OR (RA2D == destE)), excluding register 15.
REQ-021 PCWrPendingF SHALL be PCSrcD OR PCSrcE OR PCSrcM.
REQ-022 PendingWrites SHALL equal RegWriteE + RegWriteM + RegWriteW, 2-bit unsigned; the maximum of 3 SHALL NOT wrap.
REQ-023 All outputs SHALL be combinational functions of the registered state and the D inputs: zero-cycle latency, with no output registers.
REQ-024 When an instruction occupies both M and W, it SHALL be reported at both stages; M-versus-W priority is resolved downstream.

Reset
REQ-025 With reset=0 at a rising edge, every stage record SHALL clear to a bubble.
REQ-026 After reset, every Match output SHALL be 0, PendingWrites SHALL be 0, and PCWrPendingF SHALL equal PCSrcD.
REQ-027 Reset asserted mid-stream SHALL discard all in-flight records within one edge; FlushE and the D inputs are ignored on that edge.

Structure
REQ-028 The stage-record struct type, the register-width constant (4) and the PC register number (15) SHALL live in the shared pipeline package.
REQ-029 One sub-module, stage_reg, SHALL be used: a parameterised record register with synchronous active-low clear and bubble insert, instantiated three times (E, M, W).

Verification
REQ-030 ADD R1 at D, then 3 bubbles; ADD reading R1 in RA1D on the next cycle -> Match_1E_M=1 one cycle after it enters E, with PendingWrites=2.
REQ-031 LDR R2 in E (MemtoRegE=1, RegWriteE=1), RA2D=2 -> Match_12D_E=1; FlushE=1 on that edge -> E becomes a bubble and Match_12D_E=0 on the next cycle.
REQ-032 LDR R3,[R4]! (WriteBackD=1, RnD=4) followed two cycles later by a reader with RA3D=4 -> Match_3E_W_Index=1 and Match_3E_W=0.
REQ-033 A write to R15 followed by a reader with RA1D=15 -> all Match outputs 0; PCSrcD=1 pulse -> PCWrPendingF=1 for 3 consecutive cycles, then 0.
REQ-034 Three back-to-back RegWrite instructions -> PendingWrites reaches 3 and holds at 3 with a fourth writer (no wrap); reset=0 mid-stream -> all outputs 0 on the next cycle.
